// File: rtl/uart_rx_8bit.sv
// rtl/uart_rx_8bit.sv - 8-bit asynchronous serial receiver, 8N1 with optional parity
module uart_rx_8bit #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID_START = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID_BIT   = CW'(CLKS_PER_BIT - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_ok_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          perr_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q     <= S_START;
                        busy_q      <= 1'b1;
                        parity_ok_q <= 1'b1;
                    end
                end
                S_START: begin
                    // A start bit that is high again at its centre was a glitch
                    if (cnt_q == MID_START) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_q == MID_BIT) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PAR_EN ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt_q == MID_BIT) begin
                        cnt_q       <= '0;
                        parity_ok_q <= (rx_s_q == ((^shift_q) ^ PAR_ODD));
                        state_q     <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at the stop-bit centre so a following start edge is not missed
                    if (cnt_q == MID_BIT) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (parity_ok_q) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                perr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_8bit.sv
// tb/tb_uart_rx_8bit.sv - frame-level model and directed frames for uart_rx_8bit
module tb_uart_rx_8bit;

    localparam int CPB     = 16;
    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_PERR  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       dv0, fe0, pe0, busy0;
    logic       dv1, fe1, pe1, busy1;

    uart_rx_8bit #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data_out(dout0),
        .data_valid(dv0), .frame_err(fe0), .parity_err(pe0), .busy(busy0)
    );

    uart_rx_8bit #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data_out(dout1),
        .data_valid(dv1), .frame_err(fe1), .parity_err(pe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_assert = 0;
    int         n_fail = 0;
    ev_t        q0[$];
    ev_t        q1[$];
    int         dv_t0[$];
    logic [7:0] model_dout[2];

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_assert++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Each expected frame outcome is consumed by the first pulse the DUT produces
    task automatic check_dut(input int id, input logic dv, input logic fe, input logic pe,
                             input logic [7:0] dout);
        ev_t e;
        int  kind;
        int  pending;
        check($sformatf("pulse_mutex%0d", id), int'(dv) + int'(fe) + int'(pe) <= 1 ? 1 : 0, 1);
        if (dv || fe || pe) begin
            kind    = dv ? K_VALID : (fe ? K_FERR : K_PERR);
            pending = (id == 0) ? q0.size() : q1.size();
            if (pending == 0) begin
                check($sformatf("unexpected_pulse%0d", id), kind, K_NONE);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                check($sformatf("pulse_kind%0d", id), kind, e.kind);
                check_win($sformatf("pulse_time%0d", id), cyc, e.t - 1, e.t + 1);
                if (e.kind == K_VALID) model_dout[id] = e.data;
            end
        end
        check($sformatf("data_out%0d", id), dout, model_dout[id]);
    endtask

    always @(negedge clk) begin
        check_dut(0, dv0, fe0, pe0, dout0);
        check_dut(1, dv1, fe1, pe1, dout1);
        if (dv0) dv_t0.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int id, input logic b);
        if (id == 0) rx0 = b;
        else         rx1 = b;
    endtask

    task automatic hold_bit(input int id, input logic b);
        set_rx(id, b);
        tick(CPB);
    endtask

    // dut1 carries an even-parity bit; dut0 is plain 8N1
    task automatic send_frame(input int id, input logic [7:0] d, input logic par,
                              input logic stop, output int t0, output int kind);
        ev_t e;
        int  p;
        p  = (id == 1) ? 1 : 0;
        t0 = cyc;
        if (!stop)                    kind = K_FERR;
        else if (p == 1 && par != ^d) kind = K_PERR;
        else                          kind = K_VALID;
        e.kind = kind;
        e.data = d;
        e.t    = t0 + (9 + p) * CPB + CPB / 2 + 3;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
        hold_bit(id, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(id, d[i]);
        if (p == 1) hold_bit(id, par);
        hold_bit(id, stop);
    endtask

    initial begin
        int         t0;
        int         k;
        logic       seen;
        logic [7:0] b77;
        model_dout[0] = 8'h00;
        model_dout[1] = 8'h00;
        b77 = 8'h77;

        tick(3);
        check("rst_dout0", dout0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_dv0", dv0, 0);
        check("rst_busy1", busy1, 0);
        rst_n = 1'b1;
        tick(4);

        dv_t0.delete();
        send_frame(0, 8'hA5, 1'b0, 1'b1, t0, k);
        check("a5_kind", k, K_VALID);
        tick(10);
        check("a5_pulses", dv_t0.size(), 1);
        if (dv_t0.size() > 0) check_win("a5_latency", dv_t0[0] - t0, 154, 156);
        check("a5_dout", dout0, 8'hA5);
        check("a5_busy_after", busy0, 0);

        dv_t0.delete();
        send_frame(0, 8'h00, 1'b0, 1'b1, t0, k);
        send_frame(0, 8'hFF, 1'b0, 1'b1, t0, k);
        tick(10);
        check("b2b_pulses", dv_t0.size(), 2);
        if (dv_t0.size() == 2) check("b2b_spacing", dv_t0[1] - dv_t0[0], 160);
        check("b2b_dout", dout0, 8'hFF);

        seen = 1'b0;
        set_rx(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            seen = seen | busy0;
        end
        set_rx(0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            seen = seen | busy0;
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_after", busy0, 0);
        check("glitch_dout", dout0, 8'hFF);

        send_frame(0, 8'h3C, 1'b0, 1'b0, t0, k);
        check("brk_kind", k, K_FERR);
        tick(20);
        check("brk_busy_low_line", busy0, 1);
        tick(20);
        set_rx(0, 1'b1);
        tick(4);
        check("brk_busy_after", busy0, 0);
        check("brk_dout", dout0, 8'hFF);
        tick(10);
        send_frame(0, 8'h5A, 1'b0, 1'b1, t0, k);
        tick(10);
        check("after_brk_dout", dout0, 8'h5A);

        send_frame(1, 8'h01, 1'b1, 1'b1, t0, k);
        check("par_ok_kind", k, K_VALID);
        tick(20);
        check("par_ok_dout", dout1, 8'h01);
        send_frame(1, 8'h01, 1'b0, 1'b1, t0, k);
        check("par_bad_kind", k, K_PERR);
        tick(20);
        check("par_bad_dout", dout1, 8'h01);
        check("par_events_drained", q1.size(), 0);

        hold_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) hold_bit(0, b77[i]);
        set_rx(0, b77[3]);
        tick(8);
        rst_n = 1'b0;
        model_dout[0] = 8'h00;
        model_dout[1] = 8'h00;
        #1;
        check("midrst_dout", dout0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_pulses", int'(dv0) + int'(fe0) + int'(pe0), 0);
        check("midrst_dout1", dout1, 0);
        set_rx(0, 1'b1);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        dv_t0.delete();
        send_frame(0, 8'hC3, 1'b0, 1'b1, t0, k);
        tick(10);
        check("c3_dout", dout0, 8'hC3);
        check("c3_pulses", dv_t0.size(), 1);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8bit.md
Name: uart_rx_8bit

Overview:
- Asynchronous serial receiver: 8N1 by default, optional parity bit.
- Deserialises the `rx` line LSB-first into a byte.
- Presents each good byte on `data_out` with a one-cycle `data_valid` strobe.
- Sits directly upstream of the 8-bit capture register: `data_out`/`data_valid` drive its data input and load condition.

Parameters:
- `CLKS_PER_BIT`, 16, clk cycles per serial bit; even, >= 4.
- `PARITY_EN`, 0, 1 = a parity bit follows data bit 7.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; ignored when `PARITY_EN` = 0.

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `rx`  input  1  serial line, idle high, asynchronous to `clk`
- `data_out`  output  8  last good received byte
- `data_valid`  output  1  one-cycle pulse; `data_out` updated this cycle
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low
- `parity_err`  output  1  one-cycle pulse; parity mismatch
- `busy`  output  1  high whenever FSM is not in IDLE

Behaviour:
- Clock and reset: clk is the clock; reset is rst_n, asynchronous, active-low.
- Reset values: `data_out`=0x00, `data_valid`=`frame_err`=`parity_err`=`busy`=0, FSM=IDLE, bit counter=0, shift register=0x00, both synchroniser flops=1.
- Synchroniser: `rx` passes through a 2-flop synchroniser (reset to 1). The FSM uses only the synchronised value `rx_s`.
- Sample counter:
  - Width $clog2(CLKS_PER_BIT).
  - Reloaded on every state entry.
  - Mid-bit sample point = count CLKS_PER_BIT/2-1 in START, CLKS_PER_BIT-1 in all later states (centre of bit).
- States:
  - IDLE: wait for `rx_s`=0, then -> START.
  - START: at the mid-bit sample:
    - `rx_s`=1 -> glitch; return to IDLE, no output pulse.
    - `rx_s`=0 -> enter DATA.
  - DATA: sample 8 bits at 1-bit spacing; shift in LSB first. After bit 7 -> PARITY if `PARITY_EN`, else -> STOP.
  - PARITY: sample the parity bit. Expected value = XOR of the 8 data bits, XOR `PARITY_ODD`. The result is held for the STOP decision.
  - STOP: sample the stop bit.
    - `rx_s`=1 and parity OK: `data_out`<=shift register, `data_valid`=1 for one cycle, -> IDLE.
    - `rx_s`=1 and parity bad: `parity_err`=1 for one cycle, `data_out` unchanged, no `data_valid`, -> IDLE.
    - `rx_s`=0: `frame_err`=1 for one cycle (takes precedence over `parity_err`), `data_out` unchanged, -> BREAK.
  - BREAK: wait for `rx_s`=1, then -> IDLE. Long-low/break lines produce exactly one `frame_err`.
- Return to IDLE happens at the stop-bit midpoint. A start bit arriving directly after a 1-bit stop is therefore received; back-to-back frames lose nothing.
- Latency: `data_valid` rises (9+PARITY_EN)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles (±1) after the `rx` falling edge of the start bit.
- `data_valid`, `frame_err` and `parity_err` are mutually exclusive, never asserted together.
- `busy`=1 from START entry until IDLE re-entry, including BREAK.
- `data_out` is stable except in the `data_valid` cycle.
- Reset mid-frame: all state returns to reset values immediately; the partial byte is discarded; no pulse is generated. The first complete frame after reset deassertion is received normally.
- `rx` changes within a bit period are ignored except at the sample point; no majority voting.

Test Plan:
- `CLKS_PER_BIT`=16, 8N1, send 0xA5 -> one `data_valid` pulse, `data_out`=0xA5, latency 155±1 cycles from start edge, `busy` low afterwards.
- Back-to-back 0x00 then 0xFF, each with a single stop bit, no idle gap -> two `data_valid` pulses exactly 160 cycles apart, `data_out`=0x00 then 0xFF.
- `rx` low for 4 cycles then high -> `busy` pulses, returns to IDLE, no `data_valid`/`frame_err`, `data_out` unchanged.
- Send 0x3C with stop bit 0, hold `rx` low 40 more cycles, then high -> one `frame_err` pulse, `data_out` keeps prior value, `busy` stays high until `rx` high; next frame 0x5A received OK.
- `PARITY_EN`=1, `PARITY_ODD`=0: send 0x01 with parity 1 -> `data_valid`, `data_out`=0x01. Send 0x01 with parity 0 -> `parity_err` pulse only, `data_out` stays 0x01.
- Assert `rst_n` low during data bit 3 of 0x77 -> all outputs 0 at once. Release and send 0xC3 -> `data_out`=0xC3, single `data_valid`.
